uart_cmd_parser: RTL and testbench

Consumes received UART bytes and interprets a small ASCII command set that overrides the RGB LED pattern or reads it back. Sits directly downstream of the UART receiver and upstream of the transmit FIFO. Replies are pushed into the transmit FIFO through a valid/ready handshake.

---
 rtl/uart_cmd_parser.sv | 182 ++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: interprets ASCII "L<d>" / "R" commands from the UART receiver and queues 2-byte replies.
// Optional partial-command idle timeout is enabled by defining CMD_TIMEOUT_EN.
module uart_cmd_parser #(
   parameter int unsigned TIMEOUT_CYCLES = 24_000_000
) (
   input  logic       clk_in,
   input  logic       rst_n,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   output logic       rx_ready,
   output logic       tx_valid,
   output logic [7:0] tx_data,
   input  logic       tx_ready,
   output logic [2:0] led_value,
   output logic       led_override,
   output logic [7:0] err_cnt
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_GOT_L   = 3'd1,
      ST_GOT_LD  = 3'd2,
      ST_GOT_R   = 3'd3,
      ST_DISCARD = 3'd4,
      ST_RESP1   = 3'd5,
      ST_RESP2   = 3'd6
   } state_t;

   state_t     state_r, state_nxt_s;
   logic       rx_ready_r, rx_ready_nxt_s;
   logic       tx_valid_r, tx_valid_nxt_s;
   logic [7:0] tx_data_r, tx_data_nxt_s;
   logic [2:0] led_value_r, led_value_nxt_s;
   logic       led_override_r, led_override_nxt_s;
   logic [7:0] err_cnt_r, err_cnt_nxt_s;
   logic [2:0] digit_r, digit_nxt_s;
   logic       accept_s, xfer_s, is_term_s, is_digit_s, is_l_s, is_r_s, parse_s, timeout_s;

   // Case-insensitive letter match: OR-ing 0x20 folds 'A'..'Z' onto 'a'..'z'.
   function automatic logic is_letter(input logic [7:0] b, input logic [7:0] lower);
      return ((b | 8'h20) == lower);
   endfunction

   assign accept_s   = rx_valid && rx_ready_r;
   assign xfer_s     = tx_valid_r && tx_ready;
   assign is_term_s  = (rx_data == 8'h0D) || (rx_data == 8'h0A);
   assign is_digit_s = (rx_data >= 8'h30) && (rx_data <= 8'h37);
   assign is_l_s     = is_letter(rx_data, 8'h6C);
   assign is_r_s     = is_letter(rx_data, 8'h72);
   assign parse_s    = (state_r == ST_GOT_L) || (state_r == ST_GOT_LD) ||
                       (state_r == ST_GOT_R) || (state_r == ST_DISCARD);

`ifdef CMD_TIMEOUT_EN
   logic [31:0] to_cnt_r;

   // Idle-cycle counter inside a partial command; cleared by any accepted byte or outside parse states.
   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         to_cnt_r <= 32'd0;
      end else if (!parse_s || accept_s || timeout_s) begin
         to_cnt_r <= 32'd0;
      end else begin
         to_cnt_r <= to_cnt_r + 32'd1;
      end
   end

   assign timeout_s = parse_s && (to_cnt_r == TIMEOUT_CYCLES);
`else
   assign timeout_s = 1'b0;
`endif

   // State and output registers.
   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         state_r        <= ST_IDLE;
         rx_ready_r     <= 1'b0;
         tx_valid_r     <= 1'b0;
         tx_data_r      <= 8'h00;
         led_value_r    <= 3'b001;
         led_override_r <= 1'b0;
         err_cnt_r      <= 8'd0;
         digit_r        <= 3'd0;
      end else begin
         state_r        <= state_nxt_s;
         rx_ready_r     <= rx_ready_nxt_s;
         tx_valid_r     <= tx_valid_nxt_s;
         tx_data_r      <= tx_data_nxt_s;
         led_value_r    <= led_value_nxt_s;
         led_override_r <= led_override_nxt_s;
         err_cnt_r      <= err_cnt_nxt_s;
         digit_r        <= digit_nxt_s;
      end
   end

   // Next-state logic; a T in GOT_L goes straight to the error reply.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (!accept_s)       state_nxt_s = ST_IDLE;
            else if (is_l_s)     state_nxt_s = ST_GOT_L;
            else if (is_r_s)     state_nxt_s = ST_GOT_R;
            else if (is_term_s)  state_nxt_s = ST_IDLE;
            else                 state_nxt_s = ST_DISCARD;
         end
         ST_GOT_L: begin
            if (timeout_s)       state_nxt_s = ST_IDLE;
            else if (!accept_s)  state_nxt_s = ST_GOT_L;
            else if (is_digit_s) state_nxt_s = ST_GOT_LD;
            else if (is_term_s)  state_nxt_s = ST_RESP1;
            else                 state_nxt_s = ST_DISCARD;
         end
         ST_GOT_LD, ST_GOT_R: begin
            if (timeout_s)       state_nxt_s = ST_IDLE;
            else if (!accept_s)  state_nxt_s = state_r;
            else if (is_term_s)  state_nxt_s = ST_RESP1;
            else                 state_nxt_s = ST_DISCARD;
         end
         ST_DISCARD: begin
            if (timeout_s)                  state_nxt_s = ST_IDLE;
            else if (accept_s && is_term_s) state_nxt_s = ST_RESP1;
            else                            state_nxt_s = ST_DISCARD;
         end
         ST_RESP1: begin
            if (xfer_s) state_nxt_s = ST_RESP2;
            else        state_nxt_s = ST_RESP1;
         end
         ST_RESP2: begin
            if (xfer_s) state_nxt_s = ST_IDLE;
            else        state_nxt_s = ST_RESP2;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Next output values, registered above so every output comes straight from a flop.
   always_comb begin
      tx_valid_nxt_s     = tx_valid_r;
      tx_data_nxt_s      = tx_data_r;
      led_value_nxt_s    = led_value_r;
      led_override_nxt_s = led_override_r;
      err_cnt_nxt_s      = err_cnt_r;
      digit_nxt_s        = digit_r;

      if ((state_nxt_s == ST_RESP1) || (state_nxt_s == ST_RESP2)) rx_ready_nxt_s = 1'b0;
      else                                                          rx_ready_nxt_s = 1'b1;

      if ((state_r == ST_GOT_L) && (state_nxt_s == ST_GOT_LD)) digit_nxt_s = rx_data[2:0];
      else                                                     digit_nxt_s = digit_r;

      if (parse_s && (state_nxt_s == ST_RESP1)) begin
         tx_valid_nxt_s = 1'b1;
         case (state_r)
            ST_GOT_LD: begin
               tx_data_nxt_s      = 8'h4B;
               led_value_nxt_s    = digit_r;
               led_override_nxt_s = 1'b1;
            end
            ST_GOT_R: tx_data_nxt_s = 8'h30 + {5'd0, led_value_r};
            default: begin
               tx_data_nxt_s = 8'h3F;
               if (err_cnt_r != 8'hFF) err_cnt_nxt_s = err_cnt_r + 8'd1;
               else                    err_cnt_nxt_s = err_cnt_r;
            end
         endcase
      end else if ((state_r == ST_RESP1) && xfer_s) begin
         tx_data_nxt_s = 8'h0A;
      end else if ((state_r == ST_RESP2) && xfer_s) begin
         tx_valid_nxt_s = 1'b0;
      end else begin
         tx_valid_nxt_s = tx_valid_r;
      end
   end

   assign rx_ready     = rx_ready_r;
   assign tx_valid     = tx_valid_r;
   assign tx_data      = tx_data_r;
   assign led_value    = led_value_r;
   assign led_override = led_override_r;
   assign err_cnt      = err_cnt_r;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed steps plus randomized commands checked against a
// command-string model (partial command buffered, evaluated as a whole on the terminator).
module tb_uart_cmd_parser;

   localparam int unsigned TO_C = 100;

   logic       clk_in = 1'b0;
   logic       rst_n;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic [2:0] led_value;
   logic       led_override;
   logic [7:0] err_cnt;

   int checks   = 0;
   int failures = 0;

   logic [2:0] m_led;
   logic       m_ovr;
   logic [7:0] m_err;
   logic [7:0] cur[$];

   uart_cmd_parser #(.TIMEOUT_CYCLES(TO_C)) dut (
      .clk_in      (clk_in),
      .rst_n       (rst_n),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .rx_ready    (rx_ready),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_ready    (tx_ready),
      .led_value   (led_value),
      .led_override(led_override),
      .err_cnt     (err_cnt)
   );

   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] up(input logic [7:0] b);
      if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
      else return b;
   endfunction

   task automatic model_reset();
      m_led = 3'd1;
      m_ovr = 1'b0;
      m_err = 8'd0;
      cur.delete();
   endtask

   // Reference: buffer bytes; on a terminator judge the whole buffered command.
   task automatic model_byte(input logic [7:0] b, output bit rep, output logic [7:0] r0);
      rep = 1'b0;
      r0  = 8'h00;
      if (b == 8'h0D || b == 8'h0A) begin
         if (cur.size() == 0) begin
            rep = 1'b0;
         end else if (cur.size() == 2 && up(cur[0]) == 8'h4C && cur[1] >= 8'h30 && cur[1] <= 8'h37) begin
            rep   = 1'b1;
            r0    = 8'h4B;
            m_led = 3'(cur[1] - 8'h30);
            m_ovr = 1'b1;
         end else if (cur.size() == 1 && up(cur[0]) == 8'h52) begin
            rep = 1'b1;
            r0  = 8'h30 + {5'd0, m_led};
         end else begin
            rep = 1'b1;
            r0  = 8'h3F;
            if (m_err != 8'd255) m_err = m_err + 8'd1;
         end
         cur.delete();
      end else begin
         cur.push_back(b);
      end
   endtask

   task automatic collect(input logic [7:0] exp, input string tag, input int nstall);
      for (int i = 0; i < nstall; i++) begin
         tx_ready = 1'b0;
         chk(tag, tx_data, exp);
         chk1("tx_valid_hold", tx_valid, 1'b1);
         chk1("rx_ready_hold", rx_ready, 1'b0);
         tick();
      end
      tx_ready = 1'b1;
      chk(tag, tx_data, exp);
      chk1("tx_valid_xfer", tx_valid, 1'b1);
      chk1("rx_ready_xfer", rx_ready, 1'b0);
      tick();
   endtask

   task automatic send_byte(input logic [7:0] b, input int s0, input int s1);
      bit         rep;
      logic [7:0] r0;
      int         n;
      model_byte(b, rep, r0);
      rx_valid = 1'b1;
      rx_data  = b;
      n = 0;
      while (!rx_ready && n < 50) begin
         tick();
         n++;
      end
      chk1("rx_ready_before_byte", rx_ready, 1'b1);
      tick();
      rx_valid = 1'b0;
      chk("led_value", {5'd0, led_value}, {5'd0, m_led});
      chk1("led_override", led_override, m_ovr);
      chk("err_cnt", err_cnt, m_err);
      if (rep) begin
         chk1("tx_valid_after_term", tx_valid, 1'b1);
         chk1("rx_ready_in_resp", rx_ready, 1'b0);
         collect(r0, "reply_byte0", s0);
         collect(8'h0A, "reply_byte1", s1);
         chk1("rx_ready_after_resp", rx_ready, 1'b1);
         chk1("tx_valid_after_resp", tx_valid, 1'b0);
      end else begin
         chk1("tx_valid_no_reply", tx_valid, 1'b0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog_timeout simulation did not finish");
      $fatal(1);
   end

   initial begin
      int         kind;
      int         nj;
      logic [7:0] term_b;

      rst_n    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      tx_ready = 1'b1;
      model_reset();
      tick(); tick(); tick();
      chk1("reset_rx_ready", rx_ready, 1'b0);
      chk1("reset_tx_valid", tx_valid, 1'b0);
      chk("reset_tx_data", tx_data, 8'h00);
      chk("reset_led_value", {5'd0, led_value}, 8'h01);
      chk1("reset_led_override", led_override, 1'b0);
      chk("reset_err_cnt", err_cnt, 8'h00);
      rst_n = 1'b1;
      tick();
      chk1("rx_ready_after_reset", rx_ready, 1'b1);

      // Read-back of the reset pattern, lower case.
      send_byte(8'h72, 0, 0);
      send_byte(8'h0A, 0, 0);

      // Valid set: rx_ready low for exactly the two reply cycles.
      send_byte(8'h4C, 0, 0);
      send_byte(8'h35, 0, 0);
      send_byte(8'h0D, 0, 0);
      chk("led_after_L5", {5'd0, led_value}, 8'h05);

      // Bad digit then CRLF; the LF must stay silent.
      send_byte(8'h4C, 0, 0);
      send_byte(8'h39, 0, 0);
      send_byte(8'h0D, 0, 0);
      send_byte(8'h0A, 0, 0);
      chk("err_after_L9", err_cnt, 8'd1);

      // Downstream stalled for 10 cycles on the first reply byte.
      send_byte(8'h4C, 0, 0);
      send_byte(8'h33, 0, 0);
      send_byte(8'h0D, 10, 0);

      // Reset between the two reply bytes.
      send_byte(8'h4C, 0, 0);
      send_byte(8'h33, 0, 0);
      rx_valid = 1'b1;
      rx_data  = 8'h0D;
      tick();
      rx_valid = 1'b0;
      chk("midreset_first", tx_data, 8'h4B);
      tx_ready = 1'b1;
      tick();
      chk1("midreset_second_valid", tx_valid, 1'b1);
      chk("midreset_second", tx_data, 8'h0A);
      rst_n = 1'b0;
      tick();
      chk1("midreset_tx_valid", tx_valid, 1'b0);
      chk1("midreset_rx_ready", rx_ready, 1'b0);
      chk("midreset_led", {5'd0, led_value}, 8'h01);
      rst_n = 1'b1;
      model_reset();
      tick();
      chk1("midreset_rx_ready_back", rx_ready, 1'b1);
      send_byte(8'h52, 0, 0);
      send_byte(8'h0D, 0, 0);

`ifdef CMD_TIMEOUT_EN
      // Partial "L" abandoned after TO_C idle cycles; the later CR is silent.
      send_byte(8'h4C, 0, 0);
      for (int i = 0; i < int'(TO_C); i++) tick();
      cur.delete();
      send_byte(8'h0D, 0, 0);
      chk("timeout_err_cnt", err_cnt, 8'd0);
`else
      // Without the timeout a partial command waits indefinitely.
      send_byte(8'h4C, 0, 0);
      for (int i = 0; i < 150; i++) tick();
      send_byte(8'h36, 0, 0);
      send_byte(8'h0D, 0, 0);
      chk("no_timeout_led", {5'd0, led_value}, 8'h06);
`endif

      // Randomized command mix with random downstream stalls.
      for (int c = 0; c < 40; c++) begin
         kind   = int'($urandom_range(0, 3));
         term_b = ($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A;
         case (kind)
            0: begin
               send_byte(($urandom_range(0, 1) == 0) ? 8'h4C : 8'h6C, 0, 0);
               send_byte(8'h30 + 8'($urandom_range(0, 9)), 0, 0);
            end
            1: send_byte(($urandom_range(0, 1) == 0) ? 8'h52 : 8'h72, 0, 0);
            2: begin
               nj = int'($urandom_range(1, 3));
               for (int j = 0; j < nj; j++) send_byte(8'($urandom_range(32, 126)), 0, 0);
            end
            default: ;
         endcase
         send_byte(term_b, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         if ($urandom_range(0, 2) == 0) send_byte(8'h0A, 0, 0);
      end

      // Error counter saturation.
      for (int k = 0; k < 260; k++) begin
         send_byte(8'h78, 0, 0);
         send_byte(8'h0D, 0, 0);
      end
      chk("err_cnt_saturated", err_cnt, 8'd255);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
